// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_MEM   = 3'd3,
        ST_RUN       = 3'd4
    } pll_seq_state_t;

    localparam int unsigned DEF_LOCK_STABLE  = 32'd1024;
    localparam int unsigned DEF_MEM_DELAY    = 32'd256;
    localparam int unsigned DEF_LOCK_TIMEOUT = 32'd5000000;
    localparam int unsigned DEF_PLL_RST_LEN  = 32'd16;

    // Lock-loss counter must stick at its ceiling rather than wrap.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; both stages clear on the async reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock into ordered reset releases: memory domain first, CPU domain later,
// re-asserting on lock loss or user reset and pulsing the PLL reset on lock timeout.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned MEM_DELAY    = DEF_MEM_DELAY,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_LEN  = DEF_PLL_RST_LEN,
    parameter int unsigned CNT_W        = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       user_reset,
    output logic       pll_rst,
    output logic       mem_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] relock_count
);

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 32'd1);
    localparam logic [CNT_W-1:0] MEM_LAST     = CNT_W'(MEM_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_LEN - 32'd1);

    logic           lock_s;
    logic           user_s;
    pll_seq_state_t state_r;
    pll_seq_state_t state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic           cnt_hold_s;
    logic           relock_inc_s;
    logic           pll_rst_r;
    logic           mem_reset_r;
    logic           cpu_reset_r;
    logic           ready_r;
    logic [7:0]     relock_count_r;

    sync_2ff u_sync_lock (.clk(clk), .rst(rst), .d(pll_locked), .q(lock_s));
    sync_2ff u_sync_user (.clk(clk), .rst(rst), .d(user_reset), .q(user_s));

    // Next-state logic; lock loss outranks user reset, which outranks counter expiry.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_hold_s   = 1'b0;
        relock_inc_s = 1'b0;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt_s = ST_STABLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_PLL_RST;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_PLL_RST: begin
                if (cnt_r == PLLRST_LAST) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (user_s) begin
                    state_nxt_s = ST_STABLE;
                    cnt_hold_s  = 1'b1;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = ST_REL_MEM;
                end else begin
                    state_nxt_s = ST_STABLE;
                end
            end
            ST_REL_MEM: begin
                if (!lock_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (user_s) begin
                    state_nxt_s = ST_STABLE;
                end else if (cnt_r == MEM_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_REL_MEM;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt_s  = ST_WAIT_LOCK;
                    relock_inc_s = 1'b1;
                end else if (user_s) begin
                    state_nxt_s = ST_STABLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_LOCK;
            end
        endcase
    end

    // State, shared counter and outputs decoded from the next state so they move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_WAIT_LOCK;
            cnt_r          <= '0;
            pll_rst_r      <= 1'b0;
            mem_reset_r    <= 1'b1;
            cpu_reset_r    <= 1'b1;
            ready_r        <= 1'b0;
            relock_count_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || cnt_hold_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            pll_rst_r   <= (state_nxt_s == ST_PLL_RST) ? 1'b1 : 1'b0;
            mem_reset_r <= ((state_nxt_s == ST_REL_MEM) || (state_nxt_s == ST_RUN)) ? 1'b0 : 1'b1;
            cpu_reset_r <= (state_nxt_s == ST_RUN) ? 1'b0 : 1'b1;
            ready_r     <= (state_nxt_s == ST_RUN) ? 1'b1 : 1'b0;
            if (relock_inc_s) begin
                relock_count_r <= sat_inc8(relock_count_r);
            end else begin
                relock_count_r <= relock_count_r;
            end
        end
    end

    assign pll_rst      = pll_rst_r;
    assign mem_reset    = mem_reset_r;
    assign cpu_reset    = cpu_reset_r;
    assign ready        = ready_r;
    assign state        = state_r;
    assign relock_count = relock_count_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a rule-level reference model checked every cycle.
module tb_pll_reset_sequencer;

    localparam int LS  = 8;
    localparam int MD  = 4;
    localparam int TO  = 32;
    localparam int PRL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       user_reset = 1'b0;
    logic       pll_rst;
    logic       mem_reset;
    logic       cpu_reset;
    logic       ready;
    logic [2:0] state;
    logic [7:0] relock_count;

    int vectors = 0;
    int miscompares = 0;

    pll_reset_sequencer #(
        .LOCK_STABLE (LS),
        .MEM_DELAY   (MD),
        .LOCK_TIMEOUT(TO),
        .PLL_RST_LEN (PRL),
        .CNT_W       (23)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .user_reset  (user_reset),
        .pll_rst     (pll_rst),
        .mem_reset   (mem_reset),
        .cpu_reset   (cpu_reset),
        .ready       (ready),
        .state       (state),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number (0..4 as the debug encoding), time spent in phase,
    // delayed copies of the asynchronous inputs, and a saturating loss tally.
    int m_st = 0;
    int m_cnt = 0;
    int m_relock = 0;
    bit m_l1 = 0, m_l2 = 0, m_u1 = 0, m_u2 = 0;

    always @(posedge clk or posedge rst) begin : model
        int  nst;
        bit  hold;
        if (rst) begin
            m_st <= 0; m_cnt <= 0; m_relock <= 0;
            m_l1 <= 0; m_l2 <= 0; m_u1 <= 0; m_u2 <= 0;
        end else begin
            nst  = m_st;
            hold = 0;
            if (m_st == 1) begin
                if (m_cnt == PRL - 1) nst = 0;
            end else if (m_st == 0) begin
                if (m_l2) nst = 2;
                else if (m_cnt == TO - 1) nst = 1;
            end else if (!m_l2) begin
                nst = 0;
                if (m_st == 4 && m_relock < 255) m_relock <= m_relock + 1;
            end else if (m_u2) begin
                nst  = 2;
                hold = (m_st == 2);
            end else if (m_st == 2 && m_cnt == LS - 1) begin
                nst = 3;
            end else if (m_st == 3 && m_cnt == MD - 1) begin
                nst = 4;
            end
            m_cnt <= (nst != m_st || hold) ? 0 : m_cnt + 1;
            m_st  <= nst;
            m_l1 <= pll_locked; m_l2 <= m_l1;
            m_u1 <= user_reset; m_u2 <= m_u1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("state",        int'(state),        m_st);
        check("pll_rst",      int'(pll_rst),      (m_st == 1) ? 1 : 0);
        check("mem_reset",    int'(mem_reset),    (m_st == 3 || m_st == 4) ? 0 : 1);
        check("cpu_reset",    int'(cpu_reset),    (m_st == 4) ? 0 : 1);
        check("ready",        int'(ready),        (m_st == 4) ? 1 : 0);
        check("relock_count", int'(relock_count), m_relock);
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_mem", int'(mem_reset), 1);
        check("rst_cpu", int'(cpu_reset), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_pll_rst", int'(pll_rst), 0);
        check("rst_relock", int'(relock_count), 0);

        // Power-up: lock arrives at edge 0.
        rst = 1'b0; pll_locked = 1'b1;
        edges(10); check("pu_mem_e10", int'(mem_reset), 1); check("pu_state_e10", int'(state), 2);
        edges(1);  check("pu_mem_e11", int'(mem_reset), 0); check("pu_state_e11", int'(state), 3);
        edges(3);  check("pu_cpu_e14", int'(cpu_reset), 1); check("pu_ready_e14", int'(ready), 0);
        edges(1);  check("pu_cpu_e15", int'(cpu_reset), 0); check("pu_ready_e15", int'(ready), 1);
        check("pu_state_e15", int'(state), 4);

        // User reset for 5 cycles in RUN.
        user_reset = 1'b1;
        edges(2); check("ur_state_e2", int'(state), 4);
        edges(1); check("ur_state_e3", int'(state), 2);
        check("ur_mem_e3", int'(mem_reset), 1); check("ur_cpu_e3", int'(cpu_reset), 1);
        edges(2); user_reset = 1'b0;
        edges(9); check("ur_mem_e14", int'(mem_reset), 1);
        edges(1); check("ur_mem_e15", int'(mem_reset), 0);
        edges(3); check("ur_cpu_e18", int'(cpu_reset), 1);
        edges(1); check("ur_cpu_e19", int'(cpu_reset), 0); check("ur_ready_e19", int'(ready), 1);
        check("ur_relock", int'(relock_count), 0);

        // Lock loss and user reset on the same edge: lock loss wins.
        pll_locked = 1'b0; user_reset = 1'b1;
        edges(2); check("sim_state_e2", int'(state), 4);
        edges(1); check("sim_state_e3", int'(state), 0); check("sim_relock", int'(relock_count), 1);
        user_reset = 1'b0;

        // Flaky lock during qualification.
        pll_locked = 1'b1;
        edges(7); check("fl_state_e7", int'(state), 2);
        pll_locked = 1'b0;
        edges(2); check("fl_state_e9", int'(state), 2);
        pll_locked = 1'b1;
        edges(1); check("fl_state_e10", int'(state), 0);
        edges(9); check("fl_mem_e19", int'(mem_reset), 1); check("fl_state_e19", int'(state), 2);
        edges(1); check("fl_mem_e20", int'(mem_reset), 0);
        edges(4); check("fl_ready_e24", int'(ready), 1);

        // Lock loss in RUN, then enough losses to saturate the tally.
        pll_locked = 1'b0;
        edges(2); check("ll_mem_e2", int'(mem_reset), 0);
        edges(1); check("ll_mem_e3", int'(mem_reset), 1); check("ll_cpu_e3", int'(cpu_reset), 1);
        check("ll_relock", int'(relock_count), 2);
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b1;
            edges(15);
            pll_locked = 1'b0;
            edges(3);
        end
        check("ll_relock_sat", int'(relock_count), 255);
        check("ll_state_end", int'(state), 0);

        // No lock: periodic PLL reset pulses, then reset aborts a pulse.
        rst = 1'b1;
        #1 check("nl_relock_cleared", int'(relock_count), 0);
        @(negedge clk); rst = 1'b0;
        edges(31); check("nl_pll_rst_e31", int'(pll_rst), 0);
        edges(1);  check("nl_pll_rst_e32", int'(pll_rst), 1); check("nl_state_e32", int'(state), 1);
        edges(2);  check("nl_pll_rst_e34", int'(pll_rst), 1);
        edges(1);  check("nl_pll_rst_e35", int'(pll_rst), 0); check("nl_mem_e35", int'(mem_reset), 1);
        edges(31); check("nl_pll_rst_e66", int'(pll_rst), 0);
        edges(1);  check("nl_pll_rst_e67", int'(pll_rst), 1);
        edges(1);
        #2 rst = 1'b1;
        #1 check("abort_pll_rst", int'(pll_rst), 0); check("abort_state", int'(state), 0);
        @(negedge clk); rst = 1'b0;
        edges(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
